core_run_ctrl: RTL
==================

CORE_RUN_CTRL -- requirements
Module: core_run_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, fetch address width in bits.
REQ-002 SHALL have parameter HALT_ON_RST, default 0, where 1 enters HALTED after reset instead of RUN.
REQ-003 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-004 SHALL have: rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have: dbg_req  in  1  one-cycle debug register access strobe.
REQ-006 SHALL have: dbg_wr_rd  in  1  1=write, 0=read, valid with dbg_req.
REQ-007 SHALL have: dbg_addr  in  5  debug register index.
REQ-008 SHALL have: dbg_wdata  in  32  write data.
REQ-009 SHALL have: dbg_rdata  out  32  read data, registered.
REQ-010 SHALL have: dbg_rd_ready  out  1  read data valid pulse.
REQ-011 SHALL have: pc_addr  in  ADDR_WIDTH-2  current program counter [ADDR_WIDTH-1:2].
REQ-012 SHALL have: pc_load  out  1  one-cycle PC overwrite pulse.
REQ-013 SHALL have: pc_load_addr  out  ADDR_WIDTH-2  PC overwrite value.
REQ-014 SHALL have: insn_fetch_en  out  1  fetch permission to the core.
REQ-015 SHALL have: insn_fetch_ack  in  1  fetch accepted this cycle (counted only when insn_fetch_en=1).

Function
REQ-016 SHALL implement states RUN, HALTED, STEP in one registered FSM.
REQ-017 SHALL drive insn_fetch_en=1 combinationally from state in RUN and STEP, 0 in HALTED.
REQ-018 SHALL decode registers: 0 CTRL (write-only, reads 0), 1 STATUS (read-only), 2 PC, 3 SCRATCH (32-bit read/write); indices 4-31 read 0, writes ignored.
REQ-019 SHALL on CTRL write take bit0=halt, bit1=resume, bit2=step; multiple bits set: halt beats step, step beats resume.
REQ-020 SHALL transition RUN->HALTED on halt, effective next cycle (insn_fetch_en=0 in cycle after the write cycle).
REQ-021 SHALL transition HALTED->RUN on resume, HALTED->STEP on step.
REQ-022 SHALL in STEP hold insn_fetch_en=1 until first cycle with insn_fetch_ack=1, then go HALTED next cycle; exactly one acked fetch per step.
REQ-023 SHALL in STEP honour halt (abort to HALTED, no ack needed); resume and step in STEP are ignored.
REQ-024 SHALL ignore resume in RUN and halt in HALTED (no error).
REQ-025 SHALL treat step in RUN as error: ignored, sets sticky err.
REQ-026 SHALL on PC write in HALTED pulse pc_load for one cycle (cycle after write) with pc_load_addr=dbg_wdata[ADDR_WIDTH-1:2]; dbg_wdata[1:0] discarded.
REQ-027 SHALL on PC write outside HALTED not pulse pc_load and set sticky err.
REQ-028 SHALL return PC read as {pc_addr,2'b00} zero-extended to 32 bits.
REQ-029 SHALL return STATUS = {insn_cnt[15:0], 11'b0, err, 1'b0, step, run, halted}, bits 0-2 one-hot from state.
REQ-030 SHALL clear err on STATUS read; err set and cleared in the same cycle leaves err=1.
REQ-031 SHALL keep insn_cnt, 16-bit, incrementing on each insn_fetch_en&insn_fetch_ack cycle, wrapping 0xFFFF->0x0000.
REQ-032 SHALL on read register dbg_rdata and pulse dbg_rd_ready=1 one cycle after dbg_req; dbg_rd_ready=0 otherwise, including after writes.
REQ-033 SHALL hold dbg_rdata at last read value between reads.

Reset
REQ-034 SHALL on rst_n low asynchronously force state=RUN (HALTED if HALT_ON_RST=1), err=0, insn_cnt=0, SCRATCH=0, dbg_rdata=0, dbg_rd_ready=0, pc_load=0, pc_load_addr=0.
REQ-035 SHALL abort any in-progress step or pending read on reset assertion with no pc_load or dbg_rd_ready pulse after release.
REQ-036 SHALL release reset synchronously to clk via the integrating top level; block itself needs no synchronizer.

Verification
REQ-037 SHALL cover: reset release, HALT_ON_RST=0 -> insn_fetch_en=1 first cycle, STATUS read returns 0x00000002.
REQ-038 SHALL cover: CTRL write 0x1 in RUN -> insn_fetch_en=0 next cycle; STATUS read returns halted=1, low byte 0x01.
REQ-039 SHALL cover: HALTED, CTRL write 0x4, ack held low 3 cycles then high 1 -> fetch_en high 4 cycles, HALTED after, insn_cnt incremented by 1.
REQ-040 SHALL cover: HALTED, PC write 0x00001003 -> pc_load pulse 1 cycle, pc_load_addr=0x400; PC write in RUN -> no pulse, STATUS bit4=1, second STATUS read bit4=0.
REQ-041 SHALL cover: CTRL write 0x7 in HALTED -> stays HALTED; 0x6 -> STEP.
REQ-042 SHALL cover: insn_cnt preloaded to 0xFFFF by 65535 acks, one more ack -> STATUS[31:16]=0x0000; rst_n low mid-STEP -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/core_run_ctrl.sv
// core_run_ctrl: debug-register run/halt/single-step controller for a core's instruction fetch.
module core_run_ctrl #(
  parameter int ADDR_WIDTH  = 32,
  parameter bit HALT_ON_RST = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  dbg_req,
  input  logic                  dbg_wr_rd,
  input  logic [4:0]            dbg_addr,
  input  logic [31:0]           dbg_wdata,
  output logic [31:0]           dbg_rdata,
  output logic                  dbg_rd_ready,
  input  logic [ADDR_WIDTH-3:0] pc_addr,
  output logic                  pc_load,
  output logic [ADDR_WIDTH-3:0] pc_load_addr,
  output logic                  insn_fetch_en,
  input  logic                  insn_fetch_ack
);
  typedef enum logic [1:0] {RUN, HALTED, STEP} state_t;
  localparam state_t RST_ST = HALT_ON_RST ? HALTED : RUN;
  state_t state, state_n;
  logic        err, err_n;
  logic [15:0] insn_cnt;
  logic [31:0] scratch, rd_mux, status, pc_rd;
  logic        wr, rd, ctrl_wr, pc_wr, halt, resume, step, fetch, set_err, clr_err;
  assign insn_fetch_en = state != HALTED;
  assign pc_rd  = 32'({pc_addr, 2'b00});
  assign status = {insn_cnt, 11'b0, err, 1'b0, state == STEP, state == RUN, state == HALTED};
  // CTRL bit priority: halt over step over resume
  always_comb begin
    wr      = dbg_req & dbg_wr_rd;
    rd      = dbg_req & ~dbg_wr_rd;
    ctrl_wr = wr & (dbg_addr == 5'd0);
    pc_wr   = wr & (dbg_addr == 5'd2);
    halt    = ctrl_wr & dbg_wdata[0];
    step    = ctrl_wr & dbg_wdata[2] & ~dbg_wdata[0];
    resume  = ctrl_wr & dbg_wdata[1] & ~dbg_wdata[2] & ~dbg_wdata[0];
    fetch   = insn_fetch_en & insn_fetch_ack;
    rd_mux  = dbg_addr == 5'd1 ? status :
              dbg_addr == 5'd2 ? pc_rd :
              dbg_addr == 5'd3 ? scratch : 32'd0;
  end
  always_comb begin
    state_n = state;
    case (state)
      RUN:     state_n = halt ? HALTED : RUN;
      HALTED:  state_n = step ? STEP : resume ? RUN : HALTED;
      STEP:    state_n = (halt | fetch) ? HALTED : STEP;
      default: state_n = RUN;
    endcase
    set_err = (step & (state == RUN)) | (pc_wr & (state != HALTED));
    clr_err = rd & (dbg_addr == 5'd1);
    err_n   = set_err ? 1'b1 : clr_err ? 1'b0 : err;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RST_ST;
      err          <= 1'b0;
      insn_cnt     <= 16'd0;
      scratch      <= 32'd0;
      dbg_rdata    <= 32'd0;
      dbg_rd_ready <= 1'b0;
      pc_load      <= 1'b0;
      pc_load_addr <= '0;
    end else begin
      state        <= state_n;
      err          <= err_n;
      insn_cnt     <= insn_cnt + 16'(fetch);
      dbg_rd_ready <= rd;
      pc_load      <= pc_wr & (state == HALTED);
      if (wr && dbg_addr == 5'd3) scratch <= dbg_wdata;
      if (rd) dbg_rdata <= rd_mux;
      if (pc_wr && state == HALTED) pc_load_addr <= dbg_wdata[ADDR_WIDTH-1:2];
    end
  end
endmodule
